mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences a single shared memory port between two requesters: instruction fetch (read-only) and the datapath load/store unit.
- Sits between the CPU core and a unified instruction/data memory, replacing separate instruction and data memory instances.
- Data accesses win by default. A starvation counter forces a fetch grant after a bounded number of consecutive data wins.
- Fixed-latency memory; the arbiter holds address and control stable for the whole access.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MEM_LATENCY, 2, memory access cycles (>=1); mem_rdata valid in the last access cycle
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_rdata  out  DATA_W  fetched word, registered, valid when if_ack
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered, valid when d_ack on a load
d_ack  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access active
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE
grant_data  out  1  1 = current or last grant is data, 0 = fetch

Behaviour:
- Reset values:
  - state = IDLE; access counter and starve counter = 0.
  - All acks, mem_en, mem_we, busy and grant_data = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - No request: remain in IDLE.
  - Otherwise pick a winner and register its address, wdata and we (fetch forces we = 0). Set grant_data, load the counter with MEM_LATENCY-1, and go to ACCESS.
- Arbitration:
  - Only d_req high: data wins. Only if_req high: fetch wins.
  - Both high: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starve counter:
  - Data grant while if_req is high: increment, saturating at STARVE_LIMIT.
  - Any fetch grant: clear to 0.
  - Otherwise: hold.
- ACCESS:
  - Lasts exactly MEM_LATENCY cycles.
  - mem_en = 1 throughout; mem_addr and mem_wdata are held constant.
  - mem_we = 1 only in the first ACCESS cycle, and only for a store.
  - The counter decrements each cycle. On the cycle where the counter is 0, a load captures mem_rdata into the winner's rdata register, and the next state is DONE.
- DONE:
  - mem_en = 0. Exactly one of if_ack/d_ack is high, matching grant_data.
  - Next state is IDLE.
- Stores: d_ack pulses; d_rdata keeps its previous value.
- Latency: request sampled in IDLE at cycle 0 -> ack in cycle MEM_LATENCY+1. Minimum issue interval per access is MEM_LATENCY+2 cycles.
- Requester contract:
  - The requester deasserts req at the clock edge that ends its ack cycle.
  - A req still high in the following IDLE cycle is a new request, which allows back-to-back accesses.
- The losing requester keeps its req high. It is not acked and waits through the whole access.
- if_rdata and d_rdata hold their value until the next capture for the same requester.
- Request changes during ACCESS or DONE are ignored.
- Reset mid-access: the access is abandoned with no ack, mem_en/mem_we drop in the next cycle, and the starve counter clears.
- X-free: no output depends on the address or data inputs while in IDLE.

Test Plan:
- Single fetch, MEM_LATENCY=2, if_addr=0x40, memory returns 0x2002000A -> mem_en high for cycles 1-2; if_ack in cycle 3 with if_rdata = 0x2002000A; d_ack stays 0.
- Store d_addr=0x1000, d_wdata=0xDEADBEEF, then load 0x1000 -> mem_we high for exactly one cycle; load d_ack returns 0xDEADBEEF; d_rdata unchanged at the store's ack.
- if_req and d_req held high together -> grants alternate data,data,data,data,fetch for STARVE_LIMIT=4; starve_cnt returns to 0 after the fetch grant.
- if_req high alone, d_req rises during ACCESS -> fetch completes uninterrupted; data is granted in the next IDLE; acks never overlap.
- reset asserted in the second ACCESS cycle of a load -> no d_ack; busy = 0 and mem_en = 0 the next cycle; a subsequent fetch completes normally.
- MEM_LATENCY=1 back-to-back fetches with if_req held -> if_ack every 3 cycles; if_addr changes after each ack are reflected on mem_addr.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the
// load/store unit; data wins unless fetch has been starved too long.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_data
);

  localparam int CNT_W =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       starve_cnt;
  logic             we_r;
  logic             grant_r;
  logic             any_req;
  logic             pick_fetch;
  logic             last_beat;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    any_req    = if_req | d_req;
    pick_fetch = if_req &&
                 (!d_req || starve_cnt == STARVE_MAX);
    last_beat  = (cnt == '0);
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    busy       = (state != IDLE);
    grant_data = grant_r;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        // write strobe only on the first beat of a store
        mem_we = we_r && (cnt == CNT_INIT);
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        if_ack    = !grant_r;
        d_ack     = grant_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      starve_cnt <= '0;
      we_r       <= 1'b0;
      grant_r    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_r   <= !pick_fetch;
            we_r      <= !pick_fetch && d_we;
            mem_addr  <= pick_fetch ? if_addr : d_addr;
            mem_wdata <= pick_fetch ? '0 : d_wdata;
            cnt       <= CNT_INIT;
            if (pick_fetch)
              starve_cnt <= '0;
            else if (if_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ACCESS: begin
          if (!last_beat) begin
            cnt <= cnt - 1'b1;
          end else if (!we_r) begin
            if (grant_r) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LATENCY=2 with a small memory model,
// and a second at MEM_LATENCY=1 for back-to-back fetch timing.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata;
  logic [31:0] a_if_rdata, a_d_rdata;
  logic        a_if_ack, a_d_ack;
  logic        a_mem_en, a_mem_we, a_busy, a_grant;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req;
  logic [31:0] b_if_addr;
  logic [31:0] b_if_rdata, b_d_rdata;
  logic        b_if_ack, b_d_ack;
  logic        b_mem_en, b_mem_we, b_busy, b_grant;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr),
    .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .d_req(a_d_req), .d_we(a_d_we),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata),
    .busy(a_busy), .grant_data(a_grant)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(1'b0), .d_we(1'b0),
    .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_data(b_grant)
  );

  // memory A: one writable word, 0x40 holds a fixed word, else a pattern
  logic        st_valid = 1'b0;
  logic [31:0] st_addr  = 32'h0;
  logic [31:0] st_data  = 32'h0;
  always @(posedge clk) begin
    if (a_mem_we) begin
      st_valid <= 1'b1;
      st_addr  <= a_mem_addr;
      st_data  <= a_mem_wdata;
    end
  end
  assign a_mem_rdata =
    !a_mem_en ? 32'h0 :
    (st_valid && a_mem_addr == st_addr) ? st_data :
    (a_mem_addr == 32'h40) ? 32'h2002000A :
    {16'hA5A5, a_mem_addr[15:0]};
  assign b_mem_rdata =
    b_mem_en ? {16'hB000, b_mem_addr[15:0]} : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    a_if_req  = 1'b0; a_if_addr = 32'h0;
    a_d_req   = 1'b0; a_d_we    = 1'b0;
    a_d_addr  = 32'h0; a_d_wdata = 32'h0;
    b_if_req  = 1'b0; b_if_addr = 32'h0;
    step(); step();

    // reset state
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_mem_en", 32'(a_mem_en), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_grant", 32'(a_grant), 32'd0);
    check("rst_acks", {a_if_ack, a_d_ack}, 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'h0);
    check("rst_if_rdata", a_if_rdata, 32'h0);
    check("rst_d_rdata", a_d_rdata, 32'h0);
    reset = 1'b0;
    step();

    // single fetch
    a_if_req = 1'b1; a_if_addr = 32'h40;
    step();
    check("f_c1_en", 32'(a_mem_en), 32'd1);
    check("f_c1_addr", a_mem_addr, 32'h40);
    check("f_c1_we", 32'(a_mem_we), 32'd0);
    check("f_c1_grant", 32'(a_grant), 32'd0);
    check("f_c1_busy", 32'(a_busy), 32'd1);
    step();
    check("f_c2_en", 32'(a_mem_en), 32'd1);
    check("f_c2_ack", 32'(a_if_ack), 32'd0);
    step();
    check("f_c3_ack", 32'(a_if_ack), 32'd1);
    check("f_c3_dack", 32'(a_d_ack), 32'd0);
    check("f_c3_rdata", a_if_rdata, 32'h2002000A);
    check("f_c3_en", 32'(a_mem_en), 32'd0);
    a_if_req = 1'b0;
    step();
    check("f_c4_busy", 32'(a_busy), 32'd0);
    check("f_c4_ack", 32'(a_if_ack), 32'd0);

    // store then load
    a_d_req = 1'b1; a_d_we = 1'b1;
    a_d_addr = 32'h1000; a_d_wdata = 32'hDEADBEEF;
    step();
    check("st_c1_we", 32'(a_mem_we), 32'd1);
    check("st_c1_wdata", a_mem_wdata, 32'hDEADBEEF);
    check("st_c1_grant", 32'(a_grant), 32'd1);
    step();
    check("st_c2_we", 32'(a_mem_we), 32'd0);
    check("st_c2_en", 32'(a_mem_en), 32'd1);
    step();
    check("st_c3_ack", 32'(a_d_ack), 32'd1);
    check("st_c3_rdata", a_d_rdata, 32'h0);
    a_d_req = 1'b0;
    step();
    a_d_req = 1'b1; a_d_we = 1'b0;
    step();
    check("ld_c1_we", 32'(a_mem_we), 32'd0);
    step(); step();
    check("ld_c3_ack", 32'(a_d_ack), 32'd1);
    check("ld_c3_rdata", a_d_rdata, 32'hDEADBEEF);
    a_d_req = 1'b0;
    step();

    // both requesters held: four data grants then one fetch, twice
    a_if_req = 1'b1; a_if_addr = 32'h40;
    a_d_req  = 1'b1; a_d_addr  = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp_g;
      exp_g = (i % 5 == 4) ? 32'd0 : 32'd1;
      step();
      check($sformatf("starve_grant%0d", i), 32'(a_grant), exp_g);
      step(); step();
      check($sformatf("starve_ack%0d", i),
            {a_if_ack, a_d_ack}, exp_g[0] ? 32'd1 : 32'd2);
      if (i == 9) begin
        a_if_req = 1'b0; a_d_req = 1'b0;
      end
      step();
    end

    // data request rising during a fetch waits its turn
    a_if_req = 1'b1; a_if_addr = 32'h40;
    step();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h1000;
    check("ovl_c1_grant", 32'(a_grant), 32'd0);
    step(); step();
    check("ovl_f_acks", {a_if_ack, a_d_ack}, 32'd2);
    a_if_req = 1'b0;
    step();
    check("ovl_idle_acks", {a_if_ack, a_d_ack}, 32'd0);
    step();
    check("ovl_d_grant", 32'(a_grant), 32'd1);
    check("ovl_d_addr", a_mem_addr, 32'h1000);
    step(); step();
    check("ovl_d_acks", {a_if_ack, a_d_ack}, 32'd1);
    check("ovl_d_rdata", a_d_rdata, 32'hDEADBEEF);
    a_d_req = 1'b0;
    step();

    // reset during the second access cycle of a load
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h40;
    step(); step();
    check("rmid_c2_en", 32'(a_mem_en), 32'd1);
    reset = 1'b1; a_d_req = 1'b0;
    step();
    check("rmid_busy", 32'(a_busy), 32'd0);
    check("rmid_en", 32'(a_mem_en), 32'd0);
    check("rmid_dack", 32'(a_d_ack), 32'd0);
    check("rmid_rdata", a_d_rdata, 32'h0);
    reset = 1'b0;
    step();
    check("rmid_dack2", 32'(a_d_ack), 32'd0);
    a_if_req = 1'b1; a_if_addr = 32'h1000;
    step(); step(); step();
    check("rmid_f_ack", 32'(a_if_ack), 32'd1);
    check("rmid_f_rdata", a_if_rdata, 32'hDEADBEEF);
    a_if_req = 1'b0;
    step();

    // MEM_LATENCY=1: back-to-back fetches, an ack every 3 cycles
    b_if_req = 1'b1; b_if_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] ea;
      ea = 32'h100 + 32'(4 * k);
      step();
      check($sformatf("b2b_addr%0d", k), b_mem_addr, ea);
      step();
      check($sformatf("b2b_ack%0d", k), 32'(b_if_ack), 32'd1);
      check($sformatf("b2b_rdata%0d", k), b_if_rdata,
            {16'hB000, ea[15:0]});
      b_if_addr = ea + 32'd4;
      if (k == 2) b_if_req = 1'b0;
      step();
      check($sformatf("b2b_gap%0d", k), 32'(b_if_ack), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
